// File: rtl/ctrl_reg_bank_pkg.sv
// ctrl_reg_bank shared types and constants.
// Write FSM encoding, counter width, synchronizer depth.
package ctrl_reg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WRITE,
        WAIT_REL
    } wr_state_t;

    localparam int WR_CNT_W   = 8;
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/ctrl_reg_bank_if.sv
// MCU parallel bus as seen by the register bank.
// The MCU side drives, the bank samples.
interface ctrl_reg_bank_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);

    logic              CS;
    logic              WR_EN;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DATA;

    modport master (
        output CS,
        output WR_EN,
        output ADDR,
        output DATA
    );

    modport slave (
        input CS,
        input WR_EN,
        input ADDR,
        input DATA
    );

endinterface

// File: rtl/ctrl_reg_bank_bus_sync.sv
// Multi-bit flop-chain synchronizer for the async MCU bus.
// Deliberately unreset so a held bus survives a reset pulse.
module bus_sync
    import ctrl_reg_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stg [SYNC_DEPTH];

    always_ff @(posedge clk) begin
        stg[0] <= d;
        for (int i = 1; i < SYNC_DEPTH; i++) begin
            stg[i] <= stg[i-1];
        end
    end

    assign q = stg[SYNC_DEPTH-1];

endmodule

// File: rtl/ctrl_reg_bank.sv
// Clocked control-register bank fed by the MCU parallel bus.
// Glitch-filtered capture, shadow/active commit, pulse regs, read-back.
module ctrl_reg_bank
    import ctrl_reg_pkg::*;
#(
    parameter int                   NUM_REGS    = 8,
    parameter int                   DATA_W      = 16,
    parameter int                   ADDR_W      = 16,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = 16'h0001,
    parameter logic [ADDR_W-1:0]    COMMIT_ADDR = BASE_ADDR + ADDR_W'(NUM_REGS),
    parameter logic [NUM_REGS-1:0]  PULSE_MASK  = '0,
    parameter logic [DATA_W-1:0]    RESET_VAL   = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    ctrl_reg_bank_if.slave               bus,
    output logic [NUM_REGS*DATA_W-1:0]   CTRL_DATA,
    output logic                         COMMIT_PULSE,
    output logic [DATA_W-1:0]            RD_DATA,
    output logic                         ADDR_ERR,
    output logic [WR_CNT_W-1:0]          WR_CNT
);

    localparam int SW    = 2 + ADDR_W + DATA_W;
    localparam int IDX_W = $clog2(NUM_REGS);

    localparam logic [ADDR_W-1:0] NREGS_A = ADDR_W'(NUM_REGS);

    localparam longint unsigned LAST_A =
        longint'(BASE_ADDR) + longint'(NUM_REGS);
    localparam longint unsigned MAX_A =
        (64'd1 << ADDR_W) - 64'd1;

    if (LAST_A > MAX_A) begin : g_bad_base
        $error("ctrl_reg_bank: BASE_ADDR+NUM_REGS overflows ADDR_W");
    end

    if (NUM_REGS < 2 || NUM_REGS > 32) begin : g_bad_num
        $error("ctrl_reg_bank: NUM_REGS must be 2..32");
    end

    logic [SW-1:0]     s_bus;
    logic              s_cs;
    logic              s_wr;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_data;

    bus_sync #(
        .W (SW)
    ) u_sync (
        .clk (CLK),
        .d   ({bus.CS, bus.WR_EN, bus.ADDR, bus.DATA}),
        .q   (s_bus)
    );

    assign {s_cs, s_wr, s_addr, s_data} = s_bus;

    logic w_cond;
    logic rd_cond;

    assign w_cond  = !s_cs && s_wr;
    assign rd_cond = !s_cs && !s_wr;

    wr_state_t         state;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;

    // Second sample must match the first or the write is a glitch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= WAIT_REL;
            cap_addr <= '0;
            cap_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (w_cond) begin
                        state    <= ARM;
                        cap_addr <= s_addr;
                        cap_data <= s_data;
                    end
                end
                ARM: begin
                    if (w_cond && s_addr == cap_addr &&
                        s_data == cap_data) begin
                        state <= WRITE;
                    end else begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    state <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (!w_cond) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic [ADDR_W-1:0] cap_off;
    logic [ADDR_W-1:0] s_off;
    logic              cap_hit;
    logic              s_hit;
    logic [IDX_W-1:0]  cap_idx;
    logic [IDX_W-1:0]  s_idx;

    assign cap_off = cap_addr - BASE_ADDR;
    assign s_off   = s_addr - BASE_ADDR;
    assign cap_hit = (cap_addr >= BASE_ADDR) && (cap_off < NREGS_A);
    assign s_hit   = (s_addr >= BASE_ADDR) && (s_off < NREGS_A);
    assign cap_idx = cap_off[IDX_W-1:0];
    assign s_idx   = s_off[IDX_W-1:0];

    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [DATA_W-1:0] active [NUM_REGS];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= RESET_VAL;
                active[i] <= RESET_VAL;
            end
            COMMIT_PULSE <= 1'b0;
            RD_DATA      <= '0;
            ADDR_ERR     <= 1'b0;
            WR_CNT       <= '0;
        end else begin
            COMMIT_PULSE <= 1'b0;
            // Pulse registers fall back every cycle unless rewritten below.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (PULSE_MASK[i]) begin
                    active[i] <= RESET_VAL;
                end
            end
            if (rd_cond) begin
                if (!s_hit) begin
                    RD_DATA <= '0;
                end else if (PULSE_MASK[s_idx]) begin
                    RD_DATA <= RESET_VAL;
                end else begin
                    RD_DATA <= shadow[s_idx];
                end
            end
            if (state == WRITE) begin
                WR_CNT <= WR_CNT + WR_CNT_W'(1);
                if (cap_hit) begin
                    if (PULSE_MASK[cap_idx]) begin
                        active[cap_idx] <= cap_data;
                    end else begin
                        shadow[cap_idx] <= cap_data;
                    end
                end else if (cap_addr == COMMIT_ADDR) begin
                    COMMIT_PULSE <= 1'b1;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (!PULSE_MASK[i]) begin
                            active[i] <= shadow[i];
                        end
                    end
                end else begin
                    ADDR_ERR <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        CTRL_DATA = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            CTRL_DATA[i*DATA_W +: DATA_W] = active[i];
        end
    end

endmodule

// File: tb/tb_ctrl_reg_bank.sv
// Scoreboard bench for ctrl_reg_bank with a bus-level model.
// Writes queue expected outcomes; a monitor checks on WR_CNT steps.
module tb_ctrl_reg_bank;

    localparam int             NR     = 8;
    localparam int             DW     = 16;
    localparam int             AW     = 16;
    localparam logic [AW-1:0]  BASE   = 16'h0001;
    localparam logic [AW-1:0]  COMMIT = BASE + AW'(NR);
    localparam logic [NR-1:0]  PMASK  = 8'h01;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*DW-1:0] ctrl_data;
    logic            commit_pulse;
    logic [DW-1:0]   rd_data;
    logic            addr_err;
    logic [7:0]      wr_cnt;

    always #5 clk = ~clk;

    ctrl_reg_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    ctrl_reg_bank #(
        .NUM_REGS   (NR),
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .BASE_ADDR  (BASE),
        .COMMIT_ADDR(COMMIT),
        .PULSE_MASK (PMASK),
        .RESET_VAL  (16'h0000)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .bus         (bus_if),
        .CTRL_DATA   (ctrl_data),
        .COMMIT_PULSE(commit_pulse),
        .RD_DATA     (rd_data),
        .ADDR_ERR    (addr_err),
        .WR_CNT      (wr_cnt)
    );

    typedef struct {
        logic [7:0]       cnt;
        logic [NR*DW-1:0] ctrl;
        logic [NR*DW-1:0] after;
        logic             commit;
        logic             err;
    } wexp_t;

    wexp_t          wq[$];
    logic [DW-1:0]  rd_q[$];
    logic           rd_req = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_sh  [NR];
    logic [DW-1:0] m_act [NR];
    logic          m_err;
    int            m_cnt;
    logic [NR-1:0] pmask = PMASK;

    task automatic chk(input string name, input logic [NR*DW-1:0] got,
                       input logic [NR*DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] pack_act();
        logic [NR*DW-1:0] r;
        for (int i = 0; i < NR; i++) r[i*DW +: DW] = m_act[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wexp_t e;
        int off;
        off = int'(a) - int'(BASE);
        m_cnt = (m_cnt + 1) % 256;
        e.commit = 1'b0;
        if (off >= 0 && off < NR) begin
            if (!pmask[off]) m_sh[off] = d;
        end else if (a == COMMIT) begin
            for (int i = 0; i < NR; i++)
                if (!pmask[i]) m_act[i] = m_sh[i];
            e.commit = 1'b1;
        end else begin
            m_err = 1'b1;
        end
        e.after = pack_act();
        e.ctrl  = e.after;
        if (off >= 0 && off < NR && pmask[off]) e.ctrl[off*DW +: DW] = d;
        e.cnt = 8'(m_cnt);
        e.err = m_err;
        wq.push_back(e);
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        int off;
        off = int'(a) - int'(BASE);
        if (off < 0 || off >= NR) return '0;
        if (pmask[off]) return '0;
        return m_sh[off];
    endfunction

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int hold, input int gap);
        if (hold >= 4) model_write(a, d);
        @(negedge clk);
        bus_if.CS    = 1'b0;
        bus_if.WR_EN = 1'b1;
        bus_if.ADDR  = a;
        bus_if.DATA  = d;
        repeat (hold) @(negedge clk);
        bus_if.CS    = 1'b1;
        bus_if.WR_EN = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic bus_read(input logic [AW-1:0] a);
        @(negedge clk);
        bus_if.CS    = 1'b0;
        bus_if.WR_EN = 1'b0;
        bus_if.ADDR  = a;
        repeat (5) @(negedge clk);
        rd_q.push_back(model_read(a));
        rd_req = 1'b1;
        repeat (2) @(negedge clk);
        bus_if.CS = 1'b1;
        @(negedge clk);
    endtask

    logic [7:0]       prev_cnt = '0;
    logic             post_pend = 1'b0;
    logic [NR*DW-1:0] post_exp;

    always @(negedge clk) begin
        if (rst) begin
            prev_cnt  = wr_cnt;
            post_pend = 1'b0;
        end else begin
            if (post_pend) begin
                chk("ctrl_after_write", ctrl_data, post_exp);
                post_pend = 1'b0;
            end
            if (wr_cnt != prev_cnt) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write_cnt", {120'd0, wr_cnt},
                        {120'd0, prev_cnt});
                end else begin
                    wexp_t e;
                    e = wq.pop_front();
                    chk("wr_cnt", {120'd0, wr_cnt}, {120'd0, e.cnt});
                    chk("ctrl_at_write", ctrl_data, e.ctrl);
                    chk("commit_pulse", {127'd0, commit_pulse},
                        {127'd0, e.commit});
                    chk("addr_err", {127'd0, addr_err}, {127'd0, e.err});
                    post_exp  = e.after;
                    post_pend = 1'b1;
                end
            end else begin
                chk("no_stray_commit", {127'd0, commit_pulse}, '0);
            end
            prev_cnt = wr_cnt;
            if (rd_req && rd_q.size() > 0) begin
                chk("rd_data", {112'd0, rd_data}, {112'd0, rd_q.pop_front()});
                rd_req = 1'b0;
            end
        end
    end

    task automatic chk_reset_state();
        chk("rst_ctrl", ctrl_data, '0);
        chk("rst_commit", {127'd0, commit_pulse}, '0);
        chk("rst_rd", {112'd0, rd_data}, '0);
        chk("rst_err", {127'd0, addr_err}, '0);
        chk("rst_cnt", {120'd0, wr_cnt}, '0);
    endtask

    initial begin
        rst          = 1'b1;
        bus_if.CS    = 1'b1;
        bus_if.WR_EN = 1'b0;
        bus_if.ADDR  = '0;
        bus_if.DATA  = '0;
        model_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state();

        bus_write(BASE, 16'hDEAD, 1, 4);
        chk("glitch_cnt", {120'd0, wr_cnt}, '0);
        chk("glitch_ctrl", ctrl_data, '0);

        bus_write(BASE + 16'd2, 16'h1234, 6, 3);
        chk("shadow_no_ctrl", {112'd0, ctrl_data[2*DW +: DW]}, '0);
        bus_read(BASE + 16'd2);
        bus_write(COMMIT, 16'h0000, 5, 3);
        chk("commit_reg2", {112'd0, ctrl_data[2*DW +: DW]}, 128'h1234);
        chk("commit_cnt", {120'd0, wr_cnt}, 128'd2);

        bus_write(BASE, 16'h00FF, 10, 4);
        bus_read(BASE);

        bus_write(BASE + 16'd2, 16'hA5A5, 5, 3);
        bus_read(BASE + 16'd2);

        bus_write(BASE + AW'(NR) + 16'd1, 16'h5555, 4, 3);
        chk("err_set", {127'd0, addr_err}, 128'd1);
        bus_write(BASE + 16'd4, 16'h4444, 4, 3);
        chk("err_sticky", {127'd0, addr_err}, 128'd1);

        for (int n = 0; n < 60; n++) begin
            logic [AW-1:0] a;
            a = AW'(int'(BASE) - 1 + int'($urandom_range(0, NR + 2)));
            if ($urandom_range(0, 9) < 2) begin
                bus_read(a);
            end else begin
                int hold;
                hold = ($urandom_range(0, 4) == 0) ? 1 : $urandom_range(4, 8);
                bus_write(a, DW'($urandom), hold, $urandom_range(3, 5));
            end
        end

        @(negedge clk);
        bus_if.CS    = 1'b0;
        bus_if.WR_EN = 1'b1;
        bus_if.ADDR  = BASE + 16'd3;
        bus_if.DATA  = 16'hBEEF;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wq.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        bus_if.CS    = 1'b1;
        bus_if.WR_EN = 1'b0;
        repeat (4) @(negedge clk);
        chk_reset_state();
        bus_read(BASE + 16'd3);

        bus_write(BASE + 16'd5, 16'h0F0F, 4, 3);
        bus_write(COMMIT, 16'h0000, 4, 3);
        chk("post_rst_reg5", {112'd0, ctrl_data[5*DW +: DW]}, 128'h0F0F);

        for (int k = 0; k < 200 && (wq.size() > 0 || post_pend); k++)
            @(negedge clk);
        chk("scoreboard_drained", {96'd0, 32'(wq.size())}, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
